// File: rtl/mat4_pkg.sv
// Shared types and constants for the 4x4 float matrix-multiply host driver.
package mat4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_LOAD          = 3'd1,
    ST_WAIT_LOAD_ACK = 3'd2,
    ST_WAIT_RES      = 3'd3,
    ST_PRESENT       = 3'd4,
    ST_ERR           = 3'd5
  } drv_state_t;

  localparam int unsigned MAT4_N_IN  = 32;
  localparam int unsigned MAT4_N_OUT = 16;

  // IEEE-754 single-precision encoding of 1.0
  localparam logic [31:0] MAT4_FP_ONE = 32'h3F80_0000;

endpackage

// File: rtl/mat4_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the
// final cycle of the budget so the owner can abort in that same cycle.
module mat4_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] wd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (clear) begin
      wd_cnt <= '0;
    end else if (enable) begin
      wd_cnt <= wd_cnt + W'(1);
    end
  end

  assign expire = enable && (wd_cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mat4_mul_host_driver.sv
// Host-side initiator for the 4x4 float matrix-multiply accelerator: streams
// A then B into the load handshake, drains 16 results to a valid/ready output.
module mat4_mul_host_driver
  import mat4_pkg::*;
#(
  parameter int unsigned N_IN           = MAT4_N_IN,
  parameter int unsigned N_OUT          = MAT4_N_OUT,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  input  logic        acc_ready,
  output logic        acc_data_valid,
  output logic [31:0] acc_data,
  input  logic        acc_data_done,
  input  logic        acc_calc_done,
  input  logic [31:0] acc_result,
  output logic        acc_read_done
);

  drv_state_t state;
  logic [5:0] in_cnt;
  logic [4:0] out_cnt;
  logic       in_load;
  logic       start_ok;
  logic       last_in;
  logic       take_res;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_expire;

  always_comb begin
    in_load        = (state == ST_LOAD);
    start_ok       = start && ((state == ST_IDLE) || (state == ST_ERR));
    busy           = !((state == ST_IDLE) || (state == ST_ERR));
    s_ready        = in_load && acc_ready;
    acc_data_valid = in_load && s_valid && acc_ready;
    acc_data       = in_load ? s_data : '0;
    last_in        = acc_data_valid && (in_cnt == 6'(N_IN - 1));
    // a result is never taken while the previous read_done is still out
    take_res       = (state == ST_WAIT_RES) && acc_calc_done && !acc_read_done;
    wd_clear       = start_ok || last_in || take_res ||
                     ((state == ST_WAIT_LOAD_ACK) && acc_data_done);
    wd_enable      = ((state == ST_WAIT_LOAD_ACK) && !acc_data_done) ||
                     ((state == ST_WAIT_RES) && !take_res);
  end

  mat4_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (iClk),
    .rst    (iRst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state         <= ST_IDLE;
      in_cnt        <= '0;
      out_cnt       <= '0;
      error         <= 1'b0;
      done          <= 1'b0;
      m_valid       <= 1'b0;
      m_last        <= 1'b0;
      m_data        <= '0;
      acc_read_done <= 1'b0;
    end else begin
      done          <= 1'b0;
      acc_read_done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_ERR: begin
          if (start_ok) begin
            error   <= 1'b0;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (acc_data_valid) begin
            in_cnt <= in_cnt + 6'd1;
            if (last_in) begin
              state <= acc_data_done ? ST_WAIT_RES : ST_WAIT_LOAD_ACK;
            end
          end
        end
        ST_WAIT_LOAD_ACK: begin
          if (acc_data_done) begin
            state <= ST_WAIT_RES;
          end else if (wd_expire) begin
            error <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_WAIT_RES: begin
          if (take_res) begin
            m_data        <= acc_result;
            acc_read_done <= 1'b1;
            m_valid       <= 1'b1;
            m_last        <= (out_cnt == 5'(N_OUT - 1));
            state         <= ST_PRESENT;
          end else if (wd_expire) begin
            error <= 1'b1;
            state <= ST_ERR;
          end
        end
        ST_PRESENT: begin
          if (m_ready) begin
            out_cnt <= out_cnt + 5'd1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              state <= ST_WAIT_RES;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
